// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared widths and FSM encoding for the vedic multiplier/divider family
package vedic_pkg;

   localparam int DEF_DW = 8;
   localparam int DEF_VW = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_trial_sub.sv
// rtl/div_trial_sub.sv - one restoring-division trial: widened partial remainder minus divisor
module div_trial_sub
   import vedic_pkg::*;
#(
   parameter int VW = DEF_VW
) (
   input  logic [VW:0]   pr,
   input  logic [VW-1:0] divisor,
   output logic [VW-1:0] diff,
   output logic          ge
);

   // When ge is set the difference is below divisor, so the low VW bits hold it exactly.
   assign ge   = (pr >= {1'b0, divisor});
   assign diff = pr[VW-1:0] - divisor;

endmodule

// File: rtl/vedic_div_seq.sv
// rtl/vedic_div_seq.sv - iterative restoring divider, one quotient bit per clock
module vedic_div_seq
   import vedic_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int VW = DEF_VW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
);

   localparam int CW = $clog2(DW);

   div_state_t    state;
   logic [DW-1:0] dvd;
   logic [VW-1:0] dvsr;
   logic [VW-1:0] pr;
   logic [CW-1:0] cnt;

   logic [VW:0]   pr_shift;
   logic [VW-1:0] diff;
   logic          ge;
   logic [DW-1:0] dvd_next;
   logic [VW-1:0] pr_next;

   // Quotient bits shift into dvd as dividend bits shift out, so dvd ends up holding the quotient.
   assign pr_shift = {pr, dvd[DW-1]};
   assign dvd_next = {dvd[DW-2:0], ge};
   assign pr_next  = ge ? diff : pr_shift[VW-1:0];

   div_trial_sub #(.VW(VW)) u_trial (
      .pr      (pr_shift),
      .divisor (dvsr),
      .diff    (diff),
      .ge      (ge)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         cnt         <= '0;
         dvd         <= '0;
         dvsr        <= '0;
         pr          <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  if (divisor == '0) begin
                     state       <= DONE;
                     done        <= 1'b1;
                     quotient    <= '1;
                     remainder   <= '0;
                     div_by_zero <= 1'b1;
                  end else begin
                     state       <= RUN;
                     busy        <= 1'b1;
                     dvd         <= dividend;
                     dvsr        <= divisor;
                     pr          <= '0;
                     cnt         <= '0;
                     div_by_zero <= 1'b0;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               dvd <= dvd_next;
               pr  <= pr_next;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(DW - 1)) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  quotient  <= dvd_next;
                  remainder <= pr_next;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vedic_div_seq.sv
// tb/tb_vedic_div_seq.sv - directed self-checking bench for vedic_div_seq
module tb_vedic_div_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;

   int checks   = 0;
   int failures = 0;

   vedic_div_seq #(.DW(8), .VW(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present one operand pair for a single cycle, then count cycles until done (bounded).
   task automatic run_op(input logic [7:0] a, input logic [3:0] b, output int lat, output int busy_cnt);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      lat      = 1;
      busy_cnt = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   int lat, bc;
   int exp_q, exp_r;
   logic [7:0] a;
   logic [3:0] b;
   int seen_done;

   initial begin
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_quot", quotient, 0);
      chk("rst_rem", remainder, 0);
      chk("rst_dbz", div_by_zero, 0);
      rst = 1'b0;

      // 200/7 = 28 r4, done in cycle 9 after the start cycle
      run_op(8'd200, 4'd7, lat, bc);
      chk("t1_lat", lat, 9);
      chk("t1_busy_cycles", bc, 8);
      chk("t1_quot", quotient, 28);
      chk("t1_rem", remainder, 4);
      chk("t1_dbz", div_by_zero, 0);
      @(negedge clk);
      chk("t1_done_pulse", done, 0);

      run_op(8'd255, 4'd1, lat, bc);
      chk("t2a_quot", quotient, 255);
      chk("t2a_rem", remainder, 0);
      run_op(8'd15, 4'd15, lat, bc);
      chk("t2b_quot", quotient, 1);
      chk("t2b_rem", remainder, 0);
      run_op(8'd3, 4'd9, lat, bc);
      chk("t2c_quot", quotient, 0);
      chk("t2c_rem", remainder, 3);

      run_op(8'd42, 4'd0, lat, bc);
      chk("t3_lat", lat, 1);
      chk("t3_busy_cycles", bc, 0);
      chk("t3_busy", busy, 0);
      chk("t3_quot", quotient, 8'hFF);
      chk("t3_rem", remainder, 0);
      chk("t3_dbz", div_by_zero, 1);
      run_op(8'd15, 4'd15, lat, bc);
      chk("t3_dbz_clear", div_by_zero, 0);

      // reset during the fourth RUN cycle aborts the operation
      @(negedge clk);
      dividend = 8'd200; divisor = 4'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("t4_busy_before", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t4_busy", busy, 0);
      chk("t4_done", done, 0);
      chk("t4_quot", quotient, 0);
      chk("t4_rem", remainder, 0);
      chk("t4_dbz", div_by_zero, 0);
      seen_done = 0;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) seen_done = 1;
      end
      chk("t4_no_done", seen_done, 0);

      // start while busy is ignored; start in the DONE cycle is accepted without a bubble
      @(negedge clk);
      dividend = 8'd100; divisor = 4'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      dividend = 8'd50; divisor = 4'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0; dividend = 8'd0; divisor = 4'd0;
      lat = 3;
      while (!done && lat < 40) begin @(negedge clk); lat++; end
      chk("t5_lat", lat, 9);
      chk("t5_quot", quotient, 33);
      chk("t5_rem", remainder, 1);
      dividend = 8'd50; divisor = 4'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0; dividend = 8'd7; divisor = 4'd2;
      chk("t5_no_bubble", busy, 1);
      chk("t5_held_quot", quotient, 33);
      lat = 1;
      while (!done && lat < 40) begin @(negedge clk); lat++; end
      chk("t5b_lat", lat, 9);
      chk("t5b_quot", quotient, 10);
      chk("t5b_rem", remainder, 0);

      // exhaustive, each new start issued in the DONE cycle of the previous one
      for (int d = 1; d < 16; d++) begin
         for (int n = 0; n < 256; n++) begin
            a = n[7:0];
            b = d[3:0];
            exp_q = n / d;
            exp_r = n % d;
            dividend = a; divisor = b; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            lat = 1;
            while (!done && lat < 40) begin @(negedge clk); lat++; end
            chk("ex_lat", lat, 9);
            chk("ex_quot", quotient, exp_q);
            chk("ex_rem", remainder, exp_r);
            chk("ex_mul_back", quotient * b + remainder, n);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
